eip_sequencer: RTL

- Instruction-cycle controller that owns sequencing of the EIP register.
- Fetches the opcode byte at the current eip over a byte-wide req/ack memory port, then fetches 0–4 little-endian operand bytes.
- Issues exactly one EIP update per instruction: either an increment by instruction length (num_of_ope) or a load of a jump target.
- Sits between the EIP register, instruction memory and the execute stage; it is the only writer of the EIP control signals.

---
 rtl/eip_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/eip_sequencer.sv
// Instruction-cycle controller: fetches opcode/operands over a byte req/ack port and issues
// exactly one EIP update per instruction. Define EIP_SEQUENCER_TRACE_EN for retire trace outputs.
module eip_sequencer #(
    parameter int unsigned ACK_TIMEOUT      = 16,
    parameter int unsigned RESET_STATE_IDLE = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic [31:0] i_eip,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_eip_inc,
    output logic [3:0]  o_num_of_ope,
    output logic        o_eip_load,
    output logic [31:0] o_eip_load_data,
    output logic        o_instr_valid,
    output logic [7:0]  o_opcode,
    output logic [31:0] o_imm,
    output logic        o_halted,
    output logic        o_fault
`ifdef EIP_SEQUENCER_TRACE_EN
    ,
    output logic [31:0] o_retire_count,
    output logic [31:0] o_last_eip
`endif
);

    localparam logic [7:0] OpNop   = 8'h90;
    localparam logic [7:0] OpInc   = 8'h40;
    localparam logic [7:0] OpHlt   = 8'hF4;
    localparam logic [7:0] OpJmp8  = 8'hEB;
    localparam logic [7:0] OpPush  = 8'h6A;
    localparam logic [7:0] OpMov   = 8'hB8;
    localparam logic [7:0] OpJmp32 = 8'hE9;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StOperand = 3'd3,
        StExec    = 3'd4,
        StSettle  = 3'd5,
        StHalt    = 3'd6,
        StFault   = 3'd7
    } state_e;

    if (RESET_STATE_IDLE != 1) begin : g_bad_reset_state
        $error("RESET_STATE_IDLE must be 1");
    end

    // Instruction length in bytes; 0 marks an unknown opcode.
    function automatic logic [2:0] op_len(input logic [7:0] op);
        case (op)
            OpNop, OpInc, OpHlt: op_len = 3'd1;
            OpJmp8, OpPush:      op_len = 3'd2;
            OpMov, OpJmp32:      op_len = 3'd5;
            default:             op_len = 3'd0;
        endcase
    endfunction

    state_e      r_state, w_state_d;
    logic [2:0]  r_idx, w_idx_d;
    logic        r_gap, w_gap_d;
    logic [31:0] r_wait, w_wait_d;
    logic [7:0]  r_op_work, w_op_work_d;
    logic [31:0] r_imm_work, w_imm_work_d;
    logic [7:0]  r_opcode;
    logic [31:0] r_imm;

    logic [2:0]  w_len;
    logic [2:0]  w_byte_sel;
    logic [31:0] w_rel8;

    assign w_len      = op_len(r_op_work);
    assign w_byte_sel = r_idx - 3'd1;
    assign w_rel8     = {{24{r_imm_work[7]}}, r_imm_work[7:0]};

    always_comb begin
        w_state_d       = r_state;
        w_idx_d         = r_idx;
        w_gap_d         = 1'b0;
        w_wait_d        = '0;
        w_op_work_d     = r_op_work;
        w_imm_work_d    = r_imm_work;
        o_mem_req       = 1'b0;
        o_mem_addr      = '0;
        o_eip_inc       = 1'b0;
        o_num_of_ope    = '0;
        o_eip_load      = 1'b0;
        o_eip_load_data = '0;
        o_instr_valid   = 1'b0;
        o_halted        = 1'b0;
        o_fault         = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_run) w_state_d = StFetch;
            end
            StFetch: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_eip;
                if (i_mem_ack) begin
                    w_op_work_d = i_mem_rdata;
                    w_state_d   = StDecode;
                end
            end
            StDecode: begin
                w_imm_work_d = '0;
                if (w_len == 3'd0) begin
                    w_state_d = StFault;
                end else if (w_len == 3'd1) begin
                    w_state_d = StExec;
                end else begin
                    w_idx_d   = 3'd1;
                    w_state_d = StOperand;
                end
            end
            StOperand: begin
                // One idle cycle after every byte keeps requests visibly separated.
                if (!r_gap) begin
                    o_mem_req  = 1'b1;
                    o_mem_addr = i_eip + {29'd0, r_idx};
                    if (i_mem_ack) begin
                        w_imm_work_d[{w_byte_sel[1:0], 3'b000} +: 8] = i_mem_rdata;
                        if (r_idx == w_len - 3'd1) begin
                            w_idx_d   = 3'd0;
                            w_state_d = StExec;
                        end else begin
                            w_idx_d = r_idx + 3'd1;
                            w_gap_d = 1'b1;
                        end
                    end
                end
            end
            StExec: begin
                o_instr_valid = 1'b1;
                if (r_op_work == OpJmp8) begin
                    o_eip_load      = 1'b1;
                    o_eip_load_data = i_eip + 32'd2 + w_rel8;
                end else if (r_op_work == OpJmp32) begin
                    o_eip_load      = 1'b1;
                    o_eip_load_data = i_eip + 32'd5 + r_imm_work;
                end else begin
                    o_eip_inc    = 1'b1;
                    o_num_of_ope = {1'b0, w_len};
                end
                w_state_d = (r_op_work == OpHlt) ? StHalt : StSettle;
            end
            StSettle: begin
                w_state_d = i_run ? StFetch : StIdle;
            end
            StHalt: begin
                o_halted = 1'b1;
                if (!i_run) w_state_d = StIdle;
            end
            StFault: begin
                o_fault = 1'b1;
            end
            default: w_state_d = StFault;
        endcase

        // Counts consecutive unacknowledged request cycles; expiry overrides the FSM.
        if (ACK_TIMEOUT != 0 && o_mem_req && !i_mem_ack) begin
            if (r_wait == ACK_TIMEOUT - 1) begin
                w_state_d = StFault;
                w_wait_d  = '0;
            end else begin
                w_wait_d = r_wait + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_gap      <= 1'b0;
            r_wait     <= '0;
            r_op_work  <= '0;
            r_imm_work <= '0;
            r_opcode   <= '0;
            r_imm      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_idx      <= w_idx_d;
            r_gap      <= w_gap_d;
            r_wait     <= w_wait_d;
            r_op_work  <= w_op_work_d;
            r_imm_work <= w_imm_work_d;
            // Retired values become visible in the same cycle as instr_valid.
            if (w_state_d == StExec) begin
                r_opcode <= w_op_work_d;
                r_imm    <= w_imm_work_d;
            end
        end
    end

    assign o_opcode = r_opcode;
    assign o_imm    = r_imm;

`ifdef EIP_SEQUENCER_TRACE_EN
    logic [31:0] r_retire_count;
    logic [31:0] r_last_eip;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_retire_count <= '0;
            r_last_eip     <= '0;
        end else if (r_state == StExec) begin
            r_retire_count <= r_retire_count + 32'd1;
            r_last_eip     <= i_eip;
        end
    end

    assign o_retire_count = r_retire_count;
    assign o_last_eip     = r_last_eip;
`endif

endmodule
